// File: rtl/icache_line_filler_pkg.sv
// Shared definitions for the I-cache line refill engine: FSM state encodings,
// line geometry and the tag-width derivation from the physical address width.
package icache_line_filler_pkg;

   localparam int LINE_WORDS     = 4;
   localparam int PABITS_DEFAULT = 36;

   typedef enum logic [1:0] {
      FILL_IDLE  = 2'd0,
      FILL_INVAL = 2'd1,
      FILL_FILL  = 2'd2,
      FILL_VALID = 2'd3
   } fill_state_t;

   // Tag covers everything above the 12-bit index/offset field.
   function automatic int tag_bits(input int pabits);
      return pabits - 12;
   endfunction

endpackage

// File: rtl/icache_line_filler.sv
// I-cache refill engine: on a miss, invalidates the victim line, fetches the
// 4-word line critical-word-first from memory, writes each word into the data
// array through a one-cycle registered fill stage, then validates the tag.
module icache_line_filler
   import icache_line_filler_pkg::*;
#(
   parameter  int PABITS  = PABITS_DEFAULT,
   localparam int TAGBITS = tag_bits(PABITS)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               Req,
   input  logic [TAGBITS-1:0] ReqTag,
   input  logic [7:0]         ReqIndex,
   input  logic [1:0]         ReqOffset,
   input  logic               Abort,
   output logic               Busy,
   output logic               Done,
   output logic               CriticalReady,
   output logic [31:0]        CriticalWord,
   output logic               MemRead,
   output logic [PABITS-1:0]  MemAddress,
   input  logic [31:0]        MemDataIn,
   input  logic               MemReady,
   output logic               TagOwn,
   output logic [TAGBITS-1:0] SetTag,
   output logic [7:0]         SetIndex,
   output logic               InvalidateLine,
   output logic               ValidateLine,
   output logic [7:0]         LineIndex,
   output logic [1:0]         LineOffset,
   output logic [31:0]        LineIn,
   output logic               FillLine
);

   fill_state_t        r_state;
   fill_state_t        w_next;
   logic               w_accept;
   logic               w_capture;
   logic               w_last;

   logic [TAGBITS-1:0] r_tag;
   logic [7:0]         r_index;
   logic [1:0]         r_ptr;
   logic [1:0]         r_cnt;

   logic               r_fill_valid;
   logic [1:0]         r_fill_ofs;
   logic [31:0]        r_fill_data;
   logic               r_crit_ready;
   logic [31:0]        r_crit_word;

   assign w_last = (r_cnt == 2'(LINE_WORDS - 1));

   // Next-state logic; Abort in INVAL/FILL wins over any same-cycle MemReady.
   always_comb begin
      w_next    = r_state;
      w_accept  = 1'b0;
      w_capture = 1'b0;
      case (r_state)
         FILL_IDLE: begin
            if (Req) begin
               w_accept = 1'b1;
               w_next   = FILL_INVAL;
            end
         end
         FILL_INVAL: begin
            w_next = Abort ? FILL_IDLE : FILL_FILL;
         end
         FILL_FILL: begin
            if (Abort) begin
               w_next = FILL_IDLE;
            end else if (MemReady) begin
               w_capture = 1'b1;
               if (w_last) begin
                  w_next = FILL_VALID;
               end
            end
         end
         FILL_VALID: begin
            w_next = FILL_IDLE;
         end
         default: begin
            w_next = FILL_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= FILL_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Request latch and word pointer/counter (pointer wraps within the line).
   always_ff @(posedge clock) begin
      if (reset) begin
         r_tag   <= '0;
         r_index <= '0;
         r_ptr   <= '0;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_tag   <= ReqTag;
         r_index <= ReqIndex;
         r_ptr   <= ReqOffset;
         r_cnt   <= '0;
      end else if (w_capture) begin
         r_ptr   <= r_ptr + 2'd1;
         r_cnt   <= r_cnt + 2'd1;
      end
   end

   // Fill-write stage: each accepted word is written to the data array one cycle later.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_fill_valid <= 1'b0;
         r_fill_ofs   <= '0;
         r_fill_data  <= '0;
         r_crit_ready <= 1'b0;
         r_crit_word  <= '0;
      end else begin
         r_fill_valid <= w_capture;
         r_crit_ready <= w_capture && (r_cnt == 2'd0);
         if (w_capture) begin
            r_fill_ofs  <= r_ptr;
            r_fill_data <= MemDataIn;
         end
         if (w_capture && (r_cnt == 2'd0)) begin
            r_crit_word <= MemDataIn;
         end
      end
   end

   assign Busy           = (r_state != FILL_IDLE);
   assign TagOwn         = (r_state == FILL_INVAL) || (r_state == FILL_VALID);
   assign InvalidateLine = (r_state == FILL_INVAL);
   assign ValidateLine   = (r_state == FILL_VALID);
   assign Done           = (r_state == FILL_VALID);
   assign MemRead        = (r_state == FILL_FILL);
   assign MemAddress     = {r_tag, r_index, r_ptr, 2'b00};

   assign SetTag         = r_tag;
   assign SetIndex       = r_index;
   assign LineIndex      = r_index;
   assign LineOffset     = r_fill_ofs;
   assign LineIn         = r_fill_data;
   assign FillLine       = r_fill_valid;
   assign CriticalReady  = r_crit_ready;
   assign CriticalWord   = r_crit_word;

endmodule

// File: tb/tb_icache_line_filler.sv
// Bench for icache_line_filler: a memory responder returns seed+word-offset
// data, a monitor feeds a cache-set model and scoreboards fill writes,
// critical words and memory addresses against queues pushed at request time.
module tb_icache_line_filler;

   localparam int PABITS  = 36;
   localparam int TAGBITS = 24;

   logic               clock = 1'b0;
   logic               reset = 1'b1;
   logic               Req = 1'b0;
   logic [TAGBITS-1:0] ReqTag = '0;
   logic [7:0]         ReqIndex = '0;
   logic [1:0]         ReqOffset = '0;
   logic               Abort = 1'b0;
   logic [31:0]        MemDataIn = '0;
   logic               MemReady = 1'b0;

   logic               Busy, Done, CriticalReady, MemRead, TagOwn;
   logic [31:0]        CriticalWord, LineIn;
   logic [PABITS-1:0]  MemAddress;
   logic [TAGBITS-1:0] SetTag;
   logic [7:0]         SetIndex, LineIndex;
   logic               InvalidateLine, ValidateLine, FillLine;
   logic [1:0]         LineOffset;

   icache_line_filler #(.PABITS(PABITS)) dut (
      .clock(clock), .reset(reset), .Req(Req), .ReqTag(ReqTag),
      .ReqIndex(ReqIndex), .ReqOffset(ReqOffset), .Abort(Abort),
      .Busy(Busy), .Done(Done), .CriticalReady(CriticalReady),
      .CriticalWord(CriticalWord), .MemRead(MemRead), .MemAddress(MemAddress),
      .MemDataIn(MemDataIn), .MemReady(MemReady), .TagOwn(TagOwn),
      .SetTag(SetTag), .SetIndex(SetIndex), .InvalidateLine(InvalidateLine),
      .ValidateLine(ValidateLine), .LineIndex(LineIndex), .LineOffset(LineOffset),
      .LineIn(LineIn), .FillLine(FillLine)
   );

   initial forever #5 clock = ~clock;

   int cmp_count = 0;
   int err_count = 0;
   int cyc = 0;
   initial forever begin
      @(posedge clock);
      cyc++;
   end

   logic [149:0] all_out;
   assign all_out = {Busy, Done, CriticalReady, CriticalWord, MemRead, MemAddress,
                     TagOwn, SetTag, SetIndex, InvalidateLine, ValidateLine,
                     LineIndex, LineOffset, LineIn, FillLine};

   logic [PABITS-1:0] exp_addr[$];
   logic [33:0]       exp_fill[$];
   logic [31:0]       exp_crit[$];
   logic [31:0]       seed = 32'h0;
   int                ready_mode = 0;

   int n_fill, n_inval, n_valid, n_done;
   int first_fill_cyc, last_fill_cyc, crit_cyc, done_cyc, req_cyc;

   logic               c_valid [256];
   logic [TAGBITS-1:0] c_tag   [256];
   logic [31:0]        c_data  [256][4];

   logic [33:0] mon_e;
   logic [31:0] mon_c;

   // Monitor: cache-set model updates and fill/critical-word scoreboard.
   initial forever begin
      @(negedge clock);
      if (FillLine) begin
         if (n_fill == 0) first_fill_cyc = cyc;
         last_fill_cyc = cyc;
         n_fill++;
         c_data[LineIndex][LineOffset] = LineIn;
         cmp_count++;
         if (exp_fill.size() == 0) begin
            err_count++;
            $display("FAIL fill_unexpected: got ofs=%0d data=%h, required none", LineOffset, LineIn);
         end else begin
            mon_e = exp_fill.pop_front();
            if ({LineOffset, LineIn} !== mon_e) begin
               err_count++;
               $display("FAIL fill_write: got ofs=%0d data=%h, required ofs=%0d data=%h",
                        LineOffset, LineIn, mon_e[33:32], mon_e[31:0]);
            end
         end
      end
      if (CriticalReady) begin
         crit_cyc = cyc;
         cmp_count++;
         if (exp_crit.size() == 0) begin
            err_count++;
            $display("FAIL crit_unexpected: got %h, required none", CriticalWord);
         end else begin
            mon_c = exp_crit.pop_front();
            if (CriticalWord !== mon_c) begin
               err_count++;
               $display("FAIL crit_word: got %h, required %h", CriticalWord, mon_c);
            end
         end
      end
      if (InvalidateLine) begin
         n_inval++;
         c_valid[SetIndex] = 1'b0;
      end
      if (ValidateLine) begin
         n_valid++;
         c_valid[SetIndex] = 1'b1;
         c_tag[SetIndex]   = SetTag;
      end
      if (Done) begin
         n_done++;
         done_cyc = cyc;
      end
   end

   // Memory responder: drives ready/data on the falling edge and checks addresses.
   logic tog;
   initial begin
      tog = 1'b1;
      forever begin
         @(negedge clock);
         if (MemRead === 1'b1) begin
            if (ready_mode == 0) MemReady = 1'b1;
            else begin
               MemReady = tog;
               tog      = ~tog;
            end
            MemDataIn = seed + 32'(MemAddress[3:2]);
            cmp_count++;
            if (exp_addr.size() == 0) begin
               err_count++;
               $display("FAIL addr_unexpected: got %h, required none", MemAddress);
            end else begin
               if (MemAddress !== exp_addr[0]) begin
                  err_count++;
                  $display("FAIL mem_address: got %h, required %h", MemAddress, exp_addr[0]);
               end
               if (MemReady) void'(exp_addr.pop_front());
            end
         end else begin
            MemReady = 1'b0;
            tog      = 1'b1;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_counts();
      n_fill = 0; n_inval = 0; n_valid = 0; n_done = 0;
      first_fill_cyc = 0; last_fill_cyc = 0; crit_cyc = 0; done_cyc = 0;
   endtask

   task automatic push_expect(input logic [TAGBITS-1:0] tag, input logic [7:0] idx,
                              input logic [1:0] off, input int n_addr, input int n_fw);
      logic [1:0] p;
      for (int i = 0; i < n_addr; i++) begin
         p = off + 2'(i);
         exp_addr.push_back({tag, idx, p, 2'b00});
      end
      for (int i = 0; i < n_fw; i++) begin
         p = off + 2'(i);
         exp_fill.push_back({p, seed + 32'(p)});
      end
      if (n_fw > 0) exp_crit.push_back(seed + 32'(off));
   endtask

   // Request in one cycle; returns at the falling edge of the following cycle.
   task automatic do_req(input logic [TAGBITS-1:0] tag, input logic [7:0] idx,
                         input logic [1:0] off, input int n_addr, input int n_fw);
      @(negedge clock);
      Req = 1'b1; ReqTag = tag; ReqIndex = idx; ReqOffset = off;
      req_cyc = cyc;
      push_expect(tag, idx, off, n_addr, n_fw);
      @(negedge clock);
      Req = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (Busy !== 1'b0 && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (n >= 50) begin
         cmp_count++;
         err_count++;
         $display("FAIL idle_timeout: Busy=%b after %0d cycles, required 0", Busy, n);
      end
      @(negedge clock);
   endtask

   task automatic check_int(input string name, input int got, input int req);
      cmp_count++;
      if (got !== req) begin
         err_count++;
         $display("FAIL %s: got %0d, required %0d", name, got, req);
      end
   endtask

   task automatic check_queues(input string name);
      cmp_count++;
      if (exp_addr.size() != 0 || exp_fill.size() != 0 || exp_crit.size() != 0) begin
         err_count++;
         $display("FAIL %s_leftover: got addr=%0d fill=%0d crit=%0d pending, required 0/0/0",
                  name, exp_addr.size(), exp_fill.size(), exp_crit.size());
      end
      exp_addr.delete();
      exp_fill.delete();
      exp_crit.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      cmp_count++;
      if (all_out !== '0) begin
         err_count++;
         $display("FAIL reset_outputs: got %h, required 0", all_out);
      end
      reset = 1'b0;
      @(negedge clock);
      cmp_count++;
      if (Busy !== 1'b0 || MemRead !== 1'b0 || FillLine !== 1'b0) begin
         err_count++;
         $display("FAIL reset_release: got Busy=%b MemRead=%b FillLine=%b, required 0/0/0",
                  Busy, MemRead, FillLine);
      end
   endtask

   task automatic test_fill_basic();
      seed = 32'hA0; ready_mode = 0; clear_counts();
      do_req(24'h654321, 8'h76, 2'b10, 4, 4);
      wait_idle();
      check_int("basic_crit_latency", crit_cyc - req_cyc, 3);
      check_int("basic_done_latency", done_cyc - req_cyc, 6);
      check_int("basic_fill_count", n_fill, 4);
      check_int("basic_fill_span", last_fill_cyc - first_fill_cyc, 3);
      check_int("basic_invalidates", n_inval, 1);
      check_int("basic_validates", n_valid, 1);
      check_int("basic_dones", n_done, 1);
      check_queues("basic");
   endtask

   task automatic test_ready_toggle();
      seed = 32'hB0; ready_mode = 1; clear_counts();
      do_req(24'h654321, 8'h76, 2'b10, 4, 4);
      wait_idle();
      check_int("toggle_fill_count", n_fill, 4);
      check_int("toggle_validates", n_valid, 1);
      check_int("toggle_dones", n_done, 1);
      check_queues("toggle");
      ready_mode = 0;
   endtask

   task automatic test_abort();
      logic hit;
      seed = 32'hC0; clear_counts();
      do_req(24'h654321, 8'h76, 2'b10, 3, 2);
      repeat (3) @(negedge clock);
      Abort = 1'b1;
      @(negedge clock);
      Abort = 1'b0;
      cmp_count++;
      if (MemRead !== 1'b0 || Busy !== 1'b0) begin
         err_count++;
         $display("FAIL abort_idle: got MemRead=%b Busy=%b, required 0/0", MemRead, Busy);
      end
      wait_idle();
      check_int("abort_fill_count", n_fill, 2);
      check_int("abort_invalidates", n_inval, 1);
      check_int("abort_validates", n_valid, 0);
      check_int("abort_dones", n_done, 0);
      check_queues("abort");
      hit = c_valid[8'h76] && (c_tag[8'h76] == 24'h654321);
      cmp_count++;
      if (hit !== 1'b0) begin
         err_count++;
         $display("FAIL abort_line_miss: got hit=%b, required 0", hit);
      end
      // Abort coinciding with the final MemReady.
      clear_counts();
      do_req(24'h654321, 8'h76, 2'b10, 4, 3);
      repeat (4) @(negedge clock);
      Abort = 1'b1;
      @(negedge clock);
      Abort = 1'b0;
      wait_idle();
      check_int("abort_last_validates", n_valid, 0);
      check_int("abort_last_dones", n_done, 0);
      check_int("abort_last_fill_count", n_fill, 3);
      check_queues("abort_last");
   endtask

   task automatic test_back_to_back();
      int n;
      seed = 32'hD0; clear_counts();
      do_req(24'h654321, 8'h76, 2'b10, 4, 4);
      @(negedge clock);
      @(negedge clock);
      Req = 1'b1; ReqTag = 24'hABCDEF; ReqIndex = 8'h11; ReqOffset = 2'b01;
      @(negedge clock);
      Req = 1'b0;
      cmp_count++;
      if (SetTag !== 24'h654321 || SetIndex !== 8'h76) begin
         err_count++;
         $display("FAIL repulse_ignored: got tag=%h idx=%h, required 654321/76", SetTag, SetIndex);
      end
      n = 0;
      while (Done !== 1'b1 && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (n >= 50) begin
         cmp_count++;
         err_count++;
         $display("FAIL done_timeout: Done=%b, required 1", Done);
      end
      // Req raised in the Done cycle and held into IDLE; only the IDLE sample counts.
      Req = 1'b1; ReqTag = 24'hCCCCCC; ReqIndex = 8'h77; ReqOffset = 2'b00;
      exp_addr.push_back(36'hCCCCCC770);
      exp_addr.push_back(36'hCCCCCC774);
      exp_addr.push_back(36'hCCCCCC778);
      exp_addr.push_back(36'hCCCCCC77C);
      push_expect(24'hCCCCCC, 8'h77, 2'b00, 0, 4);
      @(negedge clock);
      req_cyc = cyc;
      @(negedge clock);
      Req = 1'b0;
      wait_idle();
      check_int("b2b_crit_latency", crit_cyc - req_cyc, 3);
      check_int("b2b_done_latency", done_cyc - req_cyc, 6);
      check_int("b2b_dones", n_done, 2);
      check_int("b2b_validates", n_valid, 2);
      check_int("b2b_fill_count", n_fill, 8);
      cmp_count++;
      if (SetTag !== 24'hCCCCCC) begin
         err_count++;
         $display("FAIL b2b_tag: got %h, required cccccc", SetTag);
      end
      check_queues("b2b");
   endtask

   task automatic test_reset_mid_fill();
      seed = 32'hE0; clear_counts();
      do_req(24'h654321, 8'h76, 2'b10, 2, 1);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      cmp_count++;
      if (all_out !== '0) begin
         err_count++;
         $display("FAIL midfill_reset_outputs: got %h, required 0", all_out);
      end
      reset = 1'b0;
      @(negedge clock);
      check_int("midfill_fill_count", n_fill, 1);
      check_int("midfill_validates", n_valid, 0);
      check_queues("midfill");
      clear_counts();
      do_req(24'h0BADC0, 8'h76, 2'b11, 4, 4);
      wait_idle();
      check_int("after_reset_dones", n_done, 1);
      check_int("after_reset_fill_count", n_fill, 4);
      check_queues("after_reset");
   endtask

   task automatic test_end_to_end();
      logic hit;
      seed = 32'h1234_0000; clear_counts();
      do_req(24'h13579B, 8'h40, 2'b01, 4, 4);
      wait_idle();
      check_queues("e2e");
      for (int o = 0; o < 4; o++) begin
         hit = c_valid[8'h40] && (c_tag[8'h40] == 24'h13579B);
         cmp_count++;
         if (hit !== 1'b1 || c_data[8'h40][o] !== seed + 32'(o)) begin
            err_count++;
            $display("FAIL e2e_read ofs=%0d: got hit=%b data=%h, required hit=1 data=%h",
                     o, hit, c_data[8'h40][o], seed + 32'(o));
         end
      end
      hit = c_valid[8'h40] && (c_tag[8'h40] == 24'h13579C);
      cmp_count++;
      if (hit !== 1'b0) begin
         err_count++;
         $display("FAIL e2e_other_tag: got hit=%b, required 0", hit);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         c_valid[i] = 1'b0;
         c_tag[i]   = '0;
         for (int j = 0; j < 4; j++) c_data[i][j] = '0;
      end
      clear_counts();
      test_reset();
      test_fill_basic();
      test_ready_toggle();
      test_abort();
      test_back_to_back();
      test_reset_mid_fill();
      test_end_to_end();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
      $finish;
   end

endmodule
